// File: rtl/pl_pkg.sv
// pl_pkg: shared fetch-state encoding and instruction-format constants for the pipeline front end.
package pl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam int INSTR_WID = 16;
    localparam int OPC_WID = 5;
    localparam logic [OPC_WID-1:0] OPC_HALT = 5'b11111;

    function automatic logic [OPC_WID-1:0] opcode_of(input logic [INSTR_WID-1:0] instr);
        return instr[INSTR_WID-1 -: OPC_WID];
    endfunction

endpackage

// File: rtl/pl_next_pc_sel.sv
// pl_next_pc_sel: combinational next-PC / next-state priority mux (redirects, stall, halt, increment).
module pl_next_pc_sel
    import pl_pkg::*;
#(
    parameter int PROG_CTR_WID = 10,
    parameter logic [OPC_WID-1:0] HALT_OPCODE = OPC_HALT
) (
    input  fetch_state_t            state,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [PROG_CTR_WID-1:0] branch_target,
    input  logic                    jump,
    input  logic [PROG_CTR_WID-1:0] jump_target,
    input  logic [PROG_CTR_WID-1:0] pc,
    input  logic [OPC_WID-1:0]      opcode,
    output logic [PROG_CTR_WID-1:0] next_pc,
    output fetch_state_t            next_state,
    output logic                    squash,
    output logic                    wrap
);

    logic halt_hit;

    assign halt_hit = (state == ST_RUN) && (opcode == HALT_OPCODE);

    // EX branch beats ID jump (older instruction); any redirect overrides a stall or halt.
    // BOOT and the STALL exit cycle hold the PC so the held word is presented once more.
    always_comb begin
        next_pc    = pc;
        next_state = state;
        squash     = 1'b0;
        wrap       = 1'b0;
        if (branch_taken) begin
            next_pc    = branch_target;
            next_state = ST_RUN;
            squash     = 1'b1;
        end else if (jump) begin
            next_pc    = jump_target;
            next_state = ST_RUN;
            squash     = 1'b1;
        end else if (stall) begin
            next_state = ST_STALL;
        end else if (state == ST_HALT) begin
            next_state = ST_HALT;
        end else if (state != ST_RUN) begin
            next_state = ST_RUN;
        end else if (halt_hit) begin
            next_state = ST_HALT;
        end else begin
            next_pc = pc + PROG_CTR_WID'(1);
            wrap    = &pc;
        end
    end

endmodule

// File: rtl/pl_fetch_pc.sv
// pl_fetch_pc: PC register and fetch control feeding IF/ID; FETCH_PERF_CNT_EN adds saturating perf counters.
module pl_fetch_pc
    import pl_pkg::*;
#(
    parameter int PROG_CTR_WID = 10,
    parameter logic [PROG_CTR_WID-1:0] RESET_PC = '0,
    parameter logic [OPC_WID-1:0] HALT_OPCODE = OPC_HALT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_in,
    input  logic                    branch_taken_EX,
    input  logic [PROG_CTR_WID-1:0] branch_target_EX,
    input  logic                    jump_ID,
    input  logic [PROG_CTR_WID-1:0] jump_target_ID,
    input  logic [INSTR_WID-1:0]    instr_mem_out,
    output logic [PROG_CTR_WID-1:0] instr_mem_addr,
    output logic                    fetch_valid,
    output logic                    squash_IF,
    output logic                    halted,
    output logic                    pc_wrap
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetch_cnt,
    output logic [15:0]             perf_redirect_cnt,
    output logic [15:0]             perf_stall_cnt
`endif
);

    fetch_state_t            state;
    fetch_state_t            next_state;
    logic [PROG_CTR_WID-1:0] next_pc;
    logic                    sel_squash;
    logic                    sel_wrap;
    logic                    unused_instr_bits;

    assign unused_instr_bits = ^instr_mem_out[INSTR_WID-OPC_WID-1:0];

    pl_next_pc_sel #(
        .PROG_CTR_WID (PROG_CTR_WID),
        .HALT_OPCODE  (HALT_OPCODE)
    ) u_sel (
        .state         (state),
        .stall         (stall_in),
        .branch_taken  (branch_taken_EX),
        .branch_target (branch_target_EX),
        .jump          (jump_ID),
        .jump_target   (jump_target_ID),
        .pc            (instr_mem_addr),
        .opcode        (opcode_of(instr_mem_out)),
        .next_pc       (next_pc),
        .next_state    (next_state),
        .squash        (sel_squash),
        .wrap          (sel_wrap)
    );

    // PC, fetch state and registered status outputs; fetch_valid is frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_mem_addr <= RESET_PC;
            state          <= ST_BOOT;
            fetch_valid    <= 1'b0;
            squash_IF      <= 1'b0;
            halted         <= 1'b0;
            pc_wrap        <= 1'b0;
        end else begin
            instr_mem_addr <= next_pc;
            state          <= next_state;
            fetch_valid    <= (next_state == ST_STALL) ? fetch_valid : (next_state == ST_RUN);
            squash_IF      <= sel_squash;
            halted         <= next_state == ST_HALT;
            pc_wrap        <= sel_wrap;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters sampled from the registered fetch status.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if (fetch_valid && !stall_in && !(&perf_fetch_cnt))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (squash_IF && !(&perf_redirect_cnt))
                perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
            if (state == ST_STALL && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pl_fetch_pc.sv
// tb_pl_fetch_pc: directed checks of boot, redirects, stall, halt, wrap and reset for pl_fetch_pc.
module tb_pl_fetch_pc;

    logic        clk = 1'b0;
    logic        rst, stall_in, branch_taken, jump, halt_en;
    logic [9:0]  branch_target, jump_target, addr;
    logic [15:0] instr;
    logic        fetch_valid, squash, halted, pc_wrap;

    logic        rst4, stall4, branch4, jump4;
    logic [3:0]  branch_target4, jump_target4, addr4;
    logic [15:0] instr4;
    logic        fetch_valid4, squash4, halted4, pc_wrap4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_fetch4;
    logic [15:0] perf_redirect, perf_stall, perf_redirect4, perf_stall4;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign instr  = (halt_en && addr == 10'h07F) ? 16'hF800 : 16'h0800;
    assign instr4 = 16'h0000;

    pl_fetch_pc #(.PROG_CTR_WID(10)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .stall_in         (stall_in),
        .branch_taken_EX  (branch_taken),
        .branch_target_EX (branch_target),
        .jump_ID          (jump),
        .jump_target_ID   (jump_target),
        .instr_mem_out    (instr),
        .instr_mem_addr   (addr),
        .fetch_valid      (fetch_valid),
        .squash_IF        (squash),
        .halted           (halted),
        .pc_wrap          (pc_wrap)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch),
        .perf_redirect_cnt (perf_redirect),
        .perf_stall_cnt    (perf_stall)
`endif
    );

    pl_fetch_pc #(.PROG_CTR_WID(4)) u_dut4 (
        .clk              (clk),
        .rst              (rst4),
        .stall_in         (stall4),
        .branch_taken_EX  (branch4),
        .branch_target_EX (branch_target4),
        .jump_ID          (jump4),
        .jump_target_ID   (jump_target4),
        .instr_mem_out    (instr4),
        .instr_mem_addr   (addr4),
        .fetch_valid      (fetch_valid4),
        .squash_IF        (squash4),
        .halted           (halted4),
        .pc_wrap          (pc_wrap4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch4),
        .perf_redirect_cnt (perf_redirect4),
        .perf_stall_cnt    (perf_stall4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt_en = 1'b0;
        branch_target = '0; jump_target = '0;
        rst4 = 1'b1; stall4 = 1'b0; branch4 = 1'b0; jump4 = 1'b0;
        branch_target4 = '0; jump_target4 = '0;

        tick();
        check("rst_addr", addr, 10'h000);
        check("rst_valid", fetch_valid, 0);
        check("rst_squash", squash, 0);
        check("rst_halted", halted, 0);
        check("rst_wrap", pc_wrap, 0);
        rst = 1'b0;
        tick();
        check("boot_addr", addr, 10'h000);
        check("boot_valid", fetch_valid, 1);
        tick();
        check("run_addr1", addr, 10'h001);
        tick();
        check("run_addr2", addr, 10'h002);
        tick();
        check("run_addr3", addr, 10'h003);

        jump = 1'b1; jump_target = 10'h010;
        tick();
        check("jump_addr", addr, 10'h010);
        check("jump_squash", squash, 1);
        jump = 1'b0; branch_taken = 1'b1; branch_target = 10'h155;
        tick();
        check("br_addr", addr, 10'h155);
        check("br_squash", squash, 1);
        branch_taken = 1'b0;
        tick();
        check("br_next", addr, 10'h156);
        check("br_squash_end", squash, 0);

        branch_taken = 1'b1; branch_target = 10'h020; jump = 1'b1; jump_target = 10'h300;
        tick();
        check("both_addr", addr, 10'h020);
        check("both_squash", squash, 1);
        branch_taken = 1'b0; jump = 1'b0;
        tick();
        check("both_next", addr, 10'h021);
        check("both_squash_end", squash, 0);

        jump = 1'b1; jump_target = 10'h040;
        tick();
        check("stall_setup", addr, 10'h040);
        jump = 1'b0; stall_in = 1'b1;
        tick();
        check("stall_c1", addr, 10'h040);
        check("stall_valid", fetch_valid, 1);
        tick();
        check("stall_c2", addr, 10'h040);
        tick();
        check("stall_c3", addr, 10'h040);
        stall_in = 1'b0;
        tick();
        check("stall_exit", addr, 10'h040);
        check("stall_exit_valid", fetch_valid, 1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", perf_stall, 3);
        check("perf_redirect", perf_redirect, 4);
        check("perf_fetch", perf_fetch, 10);
`endif
        tick();
        check("stall_after", addr, 10'h041);

        jump = 1'b1; jump_target = 10'h07D; halt_en = 1'b1;
        tick();
        check("halt_setup", addr, 10'h07D);
        jump = 1'b0;
        tick();
        check("halt_7e", addr, 10'h07E);
        tick();
        check("halt_word_addr", addr, 10'h07F);
        check("halt_word_valid", fetch_valid, 1);
        check("halt_word_halted", halted, 0);
        tick();
        check("halted_addr", addr, 10'h07F);
        check("halted_flag", halted, 1);
        check("halted_valid", fetch_valid, 0);
        tick();
        check("halted_hold", addr, 10'h07F);
        branch_taken = 1'b1; branch_target = 10'h010;
        tick();
        check("unhalt_addr", addr, 10'h010);
        check("unhalt_flag", halted, 0);
        check("unhalt_squash", squash, 1);
        check("unhalt_valid", fetch_valid, 1);
        branch_taken = 1'b0; halt_en = 1'b0;

        stall_in = 1'b1;
        tick();
        check("rst_stall_hold", addr, 10'h010);
        rst = 1'b1;
        tick();
        check("mid_rst_addr", addr, 10'h000);
        check("mid_rst_valid", fetch_valid, 0);
        check("mid_rst_squash", squash, 0);
`ifdef FETCH_PERF_CNT_EN
        check("mid_rst_perf", perf_stall, 0);
`endif
        rst = 1'b0; stall_in = 1'b0;
        tick();
        check("reboot_addr", addr, 10'h000);
        check("reboot_valid", fetch_valid, 1);

        rst4 = 1'b0;
        tick();
        check("w4_boot", addr4, 4'h0);
        jump4 = 1'b1; jump_target4 = 4'hE;
        tick();
        check("w4_e", addr4, 4'hE);
        check("w4_e_wrap", pc_wrap4, 0);
        jump4 = 1'b0;
        tick();
        check("w4_f", addr4, 4'hF);
        check("w4_f_wrap", pc_wrap4, 0);
        tick();
        check("w4_0", addr4, 4'h0);
        check("w4_0_wrap", pc_wrap4, 1);
        tick();
        check("w4_1", addr4, 4'h1);
        check("w4_1_wrap", pc_wrap4, 0);
        stall4 = 1'b1;
        tick();
        check("w4_stall", addr4, 4'h1);
        rst4 = 1'b1;
        tick();
        check("w4_rst_addr", addr4, 4'h0);
        check("w4_rst_valid", fetch_valid4, 0);
        rst4 = 1'b0; stall4 = 1'b0;
        tick();
        check("w4_reboot", addr4, 4'h0);
        check("w4_reboot_valid", fetch_valid4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
